// File: rtl/rtc_timekeeper_if.sv
// rtc_timekeeper_if: control, load, time and alarm signals of the timekeeper.
// master drives the controls, slave is the timekeeper itself.
interface rtc_timekeeper_if;
   logic       io_enable;
   logic       io_load;
   logic [5:0] io_load_sec;
   logic [5:0] io_load_min;
   logic [4:0] io_load_hrs;
   logic       io_load_err;
   logic [5:0] io_count_sec;
   logic [5:0] io_count_min;
   logic [4:0] io_count_hrs;
   logic [3:0] io_hrs12;
   logic       io_pm;
   logic       io_sec_pulse;
   logic       io_day_pulse;
   logic       io_alarm_set;
   logic [5:0] io_alarm_min;
   logic [4:0] io_alarm_hrs;
   logic       io_alarm_clear;
   logic       io_alarm_off;
   logic       io_alarm_armed;
   logic       io_alarm_fire;

   modport master (
      output io_enable, io_load, io_load_sec, io_load_min, io_load_hrs,
      output io_alarm_set, io_alarm_min, io_alarm_hrs,
      output io_alarm_clear, io_alarm_off,
      input  io_load_err, io_count_sec, io_count_min, io_count_hrs,
      input  io_hrs12, io_pm, io_sec_pulse, io_day_pulse,
      input  io_alarm_armed, io_alarm_fire
   );

   modport slave (
      input  io_enable, io_load, io_load_sec, io_load_min, io_load_hrs,
      input  io_alarm_set, io_alarm_min, io_alarm_hrs,
      input  io_alarm_clear, io_alarm_off,
      output io_load_err, io_count_sec, io_count_min, io_count_hrs,
      output io_hrs12, io_pm, io_sec_pulse, io_day_pulse,
      output io_alarm_armed, io_alarm_fire
   );
endinterface

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: prescaled sec/min/hrs timekeeper with load and 12h view.
// Define RTC_ALARM_EN to build the daily alarm FSM.
module rtc_timekeeper #(
   parameter int unsigned TICKS_PER_SEC = 1,
   parameter int unsigned HRS_PER_DAY   = 24
) (
   input logic             io_clock,
   input logic             io_reset,
   rtc_timekeeper_if.slave bus
);
   localparam int unsigned PW =
      (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);
   localparam logic [4:0]    HMAX = 5'(HRS_PER_DAY - 1);

   logic [PW-1:0] pre_q, pre_d;
   logic [5:0]    sec_q, sec_d;
   logic [5:0]    min_q, min_d;
   logic [4:0]    hrs_q, hrs_d;
   logic          sp_q, sp_d;
   logic          dp_q, dp_d;
   logic          err_q, err_d;
   logic          tick;
   logic          load_ok;
   logic          load_go;
   logic          alarm_err;
   logic [3:0]    hrs12;

   always_comb begin
      tick    = bus.io_enable && (pre_q == PMAX);
      load_ok = (bus.io_load_sec < 6'd60)
             && (bus.io_load_min < 6'd60)
             && (32'(bus.io_load_hrs) < HRS_PER_DAY);
      load_go = bus.io_load && load_ok;
      pre_d   = pre_q;
      sec_d   = sec_q;
      min_d   = min_q;
      hrs_d   = hrs_q;
      sp_d    = 1'b0;
      dp_d    = 1'b0;
      err_d   = (bus.io_load && !load_ok) || alarm_err;
      if (bus.io_enable) begin
         pre_d = tick ? '0 : pre_q + PW'(1);
      end
      // a valid load overrides any same-cycle tick
      if (load_go) begin
         pre_d = '0;
         sec_d = bus.io_load_sec;
         min_d = bus.io_load_min;
         hrs_d = bus.io_load_hrs;
      end else if (tick) begin
         sp_d = 1'b1;
         if (sec_q == 6'd59) begin
            sec_d = 6'd0;
            if (min_q == 6'd59) begin
               min_d = 6'd0;
               if (hrs_q == HMAX) begin
                  hrs_d = 5'd0;
                  dp_d  = 1'b1;
               end else begin
                  hrs_d = hrs_q + 5'd1;
               end
            end else begin
               min_d = min_q + 6'd1;
            end
         end else begin
            sec_d = sec_q + 6'd1;
         end
      end
   end

   always_ff @(posedge io_clock or negedge io_reset) begin
      if (!io_reset) begin
         pre_q <= '0;
         sec_q <= '0;
         min_q <= '0;
         hrs_q <= '0;
         sp_q  <= 1'b0;
         dp_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         pre_q <= pre_d;
         sec_q <= sec_d;
         min_q <= min_d;
         hrs_q <= hrs_d;
         sp_q  <= sp_d;
         dp_q  <= dp_d;
         err_q <= err_d;
      end
   end

   always_comb begin
      unique case (1'b1)
         hrs_q == 5'd0: hrs12 = 4'd12;
         hrs_q > 5'd12: hrs12 = 4'(hrs_q - 5'd12);
         default:       hrs12 = hrs_q[3:0];
      endcase
   end

`ifdef RTC_ALARM_EN
   typedef enum logic [1:0] {IDLE, ARMED, FIRING} alarm_e;

   alarm_e     st_q, st_d;
   logic [5:0] amin_q, amin_d;
   logic [4:0] ahrs_q, ahrs_d;
   logic       set_ok;
   logic       match;

   always_comb begin
      set_ok = (bus.io_alarm_min < 6'd60)
            && (32'(bus.io_alarm_hrs) < HRS_PER_DAY);
      // only a real tick can hit the alarm, never a load
      match  = tick && !load_go && (sec_d == 6'd0)
            && (min_d == amin_q) && (hrs_d == ahrs_q);
      st_d      = st_q;
      amin_d    = amin_q;
      ahrs_d    = ahrs_q;
      alarm_err = 1'b0;
      if (bus.io_alarm_off) begin
         st_d = IDLE;
      end else if (bus.io_alarm_set) begin
         if (set_ok) begin
            amin_d = bus.io_alarm_min;
            ahrs_d = bus.io_alarm_hrs;
            st_d   = ARMED;
         end else begin
            alarm_err = 1'b1;
         end
      end else begin
         case (st_q)
            ARMED:   if (match) st_d = FIRING;
            FIRING:  if (bus.io_alarm_clear) st_d = ARMED;
            default: st_d = st_q;
         endcase
      end
   end

   always_ff @(posedge io_clock or negedge io_reset) begin
      if (!io_reset) begin
         st_q   <= IDLE;
         amin_q <= '0;
         ahrs_q <= '0;
      end else begin
         st_q   <= st_d;
         amin_q <= amin_d;
         ahrs_q <= ahrs_d;
      end
   end

   assign bus.io_alarm_armed = (st_q != IDLE);
   assign bus.io_alarm_fire  = (st_q == FIRING);
`else
   logic unused_alarm;

   assign unused_alarm = ^{bus.io_alarm_set, bus.io_alarm_clear,
                           bus.io_alarm_off, bus.io_alarm_min,
                           bus.io_alarm_hrs};
   assign alarm_err          = 1'b0;
   assign bus.io_alarm_armed = 1'b0;
   assign bus.io_alarm_fire  = 1'b0;
`endif

   assign bus.io_count_sec = sec_q;
   assign bus.io_count_min = min_q;
   assign bus.io_count_hrs = hrs_q;
   assign bus.io_hrs12     = hrs12;
   assign bus.io_pm        = (hrs_q >= 5'd12);
   assign bus.io_sec_pulse = sp_q;
   assign bus.io_day_pulse = dp_q;
   assign bus.io_load_err  = err_q;
endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb_rtc_timekeeper: scoreboard bench, one DUT at 1 tick/s and one at 4.
// A seconds-of-day model predicts every cycle; a monitor compares.
module tb_rtc_timekeeper;
   localparam int HPD = 24;
   localparam int DAY = HPD * 3600;

   typedef struct {
      bit       en;
      bit       ld;
      bit [5:0] ls;
      bit [5:0] lm;
      bit [4:0] lh;
      bit       aset;
      bit [5:0] am;
      bit [4:0] ah;
      bit       aclr;
      bit       aoff;
   } stim_t;

   typedef struct {
      int pre;
      int tod;
      bit sp;
      bit dp;
      bit err;
      int ast;
      int am;
      int ah;
   } mst_t;

   typedef struct {
      int sec;
      int min;
      int hrs;
      int h12;
      bit pm;
      bit sp;
      bit dp;
      bit err;
      bit arm;
      bit fire;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   nchk = 0;
   int   npass = 0;
   mst_t m1;
   mst_t m4;
   exp_t q1[$];
   exp_t q4[$];

   always #5 clk = ~clk;

   rtc_timekeeper_if bus1 ();
   rtc_timekeeper_if bus4 ();

   rtc_timekeeper #(.TICKS_PER_SEC(1), .HRS_PER_DAY(HPD)) dut1 (
      .io_clock(clk), .io_reset(rst), .bus(bus1)
   );
   rtc_timekeeper #(.TICKS_PER_SEC(4), .HRS_PER_DAY(HPD)) dut4 (
      .io_clock(clk), .io_reset(rst), .bus(bus4)
   );

   function automatic stim_t idle();
      stim_t t;
      t = '{default: 0};
      return t;
   endfunction

   function automatic mst_t step(mst_t s, stim_t t, int tps);
      mst_t n;
      bit   tick;
      bit   lok;
      bit   aok;
      bit   hit;
      n      = s;
      n.sp   = 0;
      n.dp   = 0;
      tick   = t.en && (s.pre == tps - 1);
      lok    = (t.ls < 60) && (t.lm < 60) && (t.lh < HPD);
      n.err  = t.ld && !lok;
      if (t.en) n.pre = (s.pre + 1) % tps;
      hit = 0;
      if (t.ld && lok) begin
         n.pre = 0;
         n.tod = t.lh * 3600 + t.lm * 60 + t.ls;
      end else if (tick) begin
         n.tod = (s.tod + 1) % DAY;
         n.sp  = 1;
         n.dp  = (n.tod == 0);
         hit   = (n.tod == s.ah * 3600 + s.am * 60);
      end
`ifdef RTC_ALARM_EN
      aok = (t.am < 60) && (t.ah < HPD);
      if (t.aoff) begin
         n.ast = 0;
      end else if (t.aset) begin
         if (aok) begin
            n.ast = 1;
            n.am  = t.am;
            n.ah  = t.ah;
         end else begin
            n.err = 1;
         end
      end else if (s.ast == 1 && hit) begin
         n.ast = 2;
      end else if (s.ast == 2 && t.aclr) begin
         n.ast = 1;
      end
`else
      aok = 0;
      if (aok && hit) n.ast = 0;
`endif
      return n;
   endfunction

   function automatic exp_t view(mst_t s);
      exp_t e;
      e.hrs  = s.tod / 3600;
      e.min  = (s.tod / 60) % 60;
      e.sec  = s.tod % 60;
      e.h12  = (e.hrs % 12 == 0) ? 12 : e.hrs % 12;
      e.pm   = (e.hrs >= 12);
      e.sp   = s.sp;
      e.dp   = s.dp;
      e.err  = s.err;
      e.arm  = (s.ast != 0);
      e.fire = (s.ast == 2);
      return e;
   endfunction

   function automatic exp_t grab(logic [5:0] s, logic [5:0] m,
                                 logic [4:0] h, logic [3:0] h12,
                                 logic pm, logic sp, logic dp,
                                 logic err, logic arm, logic fire);
      exp_t g;
      g.sec  = int'(s);
      g.min  = int'(m);
      g.hrs  = int'(h);
      g.h12  = int'(h12);
      g.pm   = pm;
      g.sp   = sp;
      g.dp   = dp;
      g.err  = err;
      g.arm  = arm;
      g.fire = fire;
      return g;
   endfunction

   function automatic string fmt(exp_t e);
      return $sformatf("%0d:%0d:%0d h12=%0d pm=%0d sp=%0d dp=%0d err=%0d arm=%0d fire=%0d",
                       e.hrs, e.min, e.sec, e.h12, e.pm, e.sp, e.dp,
                       e.err, e.arm, e.fire);
   endfunction

   task automatic cmp(string nm, exp_t e, exp_t g);
      nchk++;
      if (fmt(e) == fmt(g)) npass++;
      else $display("FAIL %s @%0t: got %s, want %s",
                    nm, $time, fmt(g), fmt(e));
   endtask

   task automatic chk(string nm, int act, int exp);
      nchk++;
      if (act == exp) npass++;
      else $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, act, exp);
   endtask

   always begin
      @(posedge clk);
      #1;
      if (q1.size() > 0)
         cmp("dut1", q1.pop_front(),
             grab(bus1.io_count_sec, bus1.io_count_min, bus1.io_count_hrs,
                  bus1.io_hrs12, bus1.io_pm, bus1.io_sec_pulse,
                  bus1.io_day_pulse, bus1.io_load_err,
                  bus1.io_alarm_armed, bus1.io_alarm_fire));
      if (q4.size() > 0)
         cmp("dut4", q4.pop_front(),
             grab(bus4.io_count_sec, bus4.io_count_min, bus4.io_count_hrs,
                  bus4.io_hrs12, bus4.io_pm, bus4.io_sec_pulse,
                  bus4.io_day_pulse, bus4.io_load_err,
                  bus4.io_alarm_armed, bus4.io_alarm_fire));
   end

   task automatic apply(stim_t t);
      bus1.io_enable = t.en;      bus4.io_enable = t.en;
      bus1.io_load = t.ld;        bus4.io_load = t.ld;
      bus1.io_load_sec = t.ls;    bus4.io_load_sec = t.ls;
      bus1.io_load_min = t.lm;    bus4.io_load_min = t.lm;
      bus1.io_load_hrs = t.lh;    bus4.io_load_hrs = t.lh;
      bus1.io_alarm_set = t.aset; bus4.io_alarm_set = t.aset;
      bus1.io_alarm_min = t.am;   bus4.io_alarm_min = t.am;
      bus1.io_alarm_hrs = t.ah;   bus4.io_alarm_hrs = t.ah;
      bus1.io_alarm_clear = t.aclr;
      bus4.io_alarm_clear = t.aclr;
      bus1.io_alarm_off = t.aoff;
      bus4.io_alarm_off = t.aoff;
   endtask

   task automatic cycle(stim_t t);
      @(negedge clk);
      apply(t);
      m1 = step(m1, t, 1);
      m4 = step(m4, t, 4);
      q1.push_back(view(m1));
      q4.push_back(view(m4));
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      apply(idle());
      m1 = '{default: 0};
      m4 = '{default: 0};
      #1;
      chk("rst_sec", int'(bus1.io_count_sec), 0);
      chk("rst_hrs12", int'(bus1.io_hrs12), 12);
      chk("rst_pm_sp", int'({bus1.io_pm, bus1.io_sec_pulse}), 0);
      chk("rst_alarm", int'({bus1.io_alarm_armed, bus1.io_alarm_fire}), 0);
      chk("rst4_alarm", int'({bus4.io_alarm_armed, bus4.io_alarm_fire}), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   function automatic stim_t ld(int h, int m, int s, bit en);
      stim_t t;
      t    = idle();
      t.en = en;
      t.ld = 1;
      t.lh = 5'(h);
      t.lm = 6'(m);
      t.ls = 6'(s);
      return t;
   endfunction

   function automatic stim_t aset(int h, int m, bit off);
      stim_t t;
      t      = idle();
      t.aset = 1;
      t.ah   = 5'(h);
      t.am   = 6'(m);
      t.aoff = off;
      return t;
   endfunction

   function automatic stim_t rnd();
      stim_t t;
      int    r;
      int    x;
      t    = idle();
      t.en = ($urandom_range(0, 9) != 0);
      r    = int'($urandom_range(0, 99));
      if (r < 5) begin
         x = ($urandom_range(0, 1) == 1) ? DAY - 1 - int'($urandom_range(0, 6))
                                         : int'($urandom_range(0, DAY - 1));
         t = ld(x / 3600, (x / 60) % 60, x % 60, t.en);
         case ($urandom_range(0, 5))
            0:       t.ls = 6'(60 + $urandom_range(0, 3));
            1:       t.lh = 5'(HPD + $urandom_range(0, 7));
            default: t.ld = 1;
         endcase
      end else if (r < 8) begin
         x      = (m1.tod / 60 + 1) % (HPD * 60);
         t.aset = 1;
         t.am   = 6'(x % 60);
         t.ah   = 5'(x / 60);
         if ($urandom_range(0, 4) == 0) t.am = 6'(60 + $urandom_range(0, 3));
      end else if (r < 12) begin
         t.aclr = 1;
      end else if (r < 13) begin
         t.aoff = 1;
      end
      return t;
   endfunction

   initial begin
      stim_t t;
      apply(idle());
      m1 = '{default: 0};
      m4 = '{default: 0};
      do_reset();

      t    = idle();
      t.en = 1;
      repeat (7200) cycle(t);
      settle();
      chk("run_hrs", int'(bus1.io_count_hrs), 2);
      chk("run_min_sec", int'({bus1.io_count_min, bus1.io_count_sec}), 0);
      chk("run_h12", int'(bus1.io_hrs12), 2);
      chk("run_pm", int'(bus1.io_pm), 0);
      chk("run_sp", int'(bus1.io_sec_pulse), 1);

      do_reset();
      repeat (10) cycle(t);
      settle();
      chk("pre4_sec", int'(bus4.io_count_sec), 2);
      repeat (5) cycle(idle());
      settle();
      chk("hold4_sec", int'(bus4.io_count_sec), 2);
      chk("hold4_sp", int'(bus4.io_sec_pulse), 0);
      cycle(t);
      settle();
      chk("pre4_nottick", int'(bus4.io_count_sec), 2);
      cycle(t);
      settle();
      chk("pre4_tick", int'(bus4.io_count_sec), 3);

      cycle(ld(12, 0, 0, 0));
      settle();
      chk("noon_h12", int'(bus1.io_hrs12), 12);
      chk("noon_pm", int'(bus1.io_pm), 1);
      cycle(ld(23, 59, 58, 1));
      settle();
      chk("ldtick_sec", int'(bus1.io_count_sec), 58);
      chk("ldtick_sp", int'(bus1.io_sec_pulse), 0);
      chk("eve_h12", int'(bus1.io_hrs12), 11);
      chk("eve_pm", int'(bus1.io_pm), 1);
      cycle(t);
      cycle(t);
      settle();
      chk("wrap_hrs", int'(bus1.io_count_hrs), 0);
      chk("wrap_dp", int'(bus1.io_day_pulse), 1);
      chk("wrap_h12", int'(bus1.io_hrs12), 12);
      chk("wrap_pm", int'(bus1.io_pm), 0);
      cycle(t);
      settle();
      chk("wrap_dp_once", int'(bus1.io_day_pulse), 0);

      cycle(ld(0, 0, 60, 0));
      settle();
      chk("bad_err", int'(bus1.io_load_err), 1);
      chk("bad_sec", int'(bus1.io_count_sec), 1);
      cycle(idle());
      settle();
      chk("bad_err_pulse", int'(bus1.io_load_err), 0);

`ifdef RTC_ALARM_EN
      do_reset();
      cycle(aset(0, 2, 0));
      settle();
      chk("al_armed", int'({bus1.io_alarm_armed, bus1.io_alarm_fire}), 2);
      repeat (119) cycle(t);
      settle();
      chk("al_early", int'(bus1.io_alarm_fire), 0);
      cycle(t);
      settle();
      chk("al_fire", int'(bus1.io_alarm_fire), 1);
      repeat (3) cycle(t);
      settle();
      chk("al_sticky", int'(bus1.io_alarm_fire), 1);
      t.aclr = 1;
      t.en   = 0;
      cycle(t);
      settle();
      chk("al_clear", int'({bus1.io_alarm_armed, bus1.io_alarm_fire}), 2);
      cycle(aset(0, 2, 1));
      settle();
      chk("al_off_wins", int'(bus1.io_alarm_armed), 0);
      cycle(aset(0, 2, 0));
      cycle(ld(0, 2, 0, 1));
      settle();
      chk("al_load_nofire", int'({bus1.io_alarm_armed, bus1.io_alarm_fire}), 2);
      cycle(ld(0, 1, 59, 0));
      t      = idle();
      t.en   = 1;
      cycle(t);
      settle();
      chk("al_refire", int'(bus1.io_alarm_fire), 1);
      do_reset();
`endif

      repeat (3000) cycle(rnd());
      settle();
      chk("queues_drained", q1.size() + q4.size(), 0);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
